// File: rtl/mult_share_pkg.sv
// Shared types and widths for the mult_share multiplier arbiter.
// Imported by mult_share and its multiplier pipeline, mult_pipe.
package mult_share_pkg;

    localparam int OP_W        = 32;
    localparam int PROD_W      = 64;
    localparam int MAX_CLIENTS = 8;
    localparam int ID_W        = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } state_t;

endpackage

// File: rtl/mult_pipe.sv
// Two-stage signed multiplier: operand registers followed by a product register.
// The pipeline never stalls, so a product appears two edges after its operands.
module mult_pipe
    import mult_share_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [OP_W-1:0]   a,
    input  logic signed [OP_W-1:0]   b,
    output logic signed [PROD_W-1:0] p
);

    logic signed [OP_W-1:0] a_q;
    logic signed [OP_W-1:0] b_q;

    // NOTE: non-blocking assignments let p use the a_q/b_q values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p   <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
            p   <= PROD_W'(a_q) * PROD_W'(b_q);
        end
    end

endmodule

// File: rtl/mult_share.sv
// One signed 32x32 multiplier shared by NUM_CLIENTS DSP clients through a grant FSM.
// Defining MULT_SHARE_RR_EN selects round-robin arbitration; otherwise the lowest index wins.
module mult_share
    import mult_share_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CLIENTS-1:0]              req,
    output logic [NUM_CLIENTS-1:0]              start,
    input  logic [NUM_CLIENTS-1:0]              finish,
    input  logic [NUM_CLIENTS-1:0][OP_W-1:0]    mult_a,
    input  logic [NUM_CLIENTS-1:0][OP_W-1:0]    mult_b,
    output logic signed [PROD_W-1:0]            mult_p,
    output logic                                busy,
    output logic [ID_W-1:0]                     grant_id,
    output logic                                timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t                 state;
    logic [CNT_W-1:0]       run_cnt;
    logic                   found;
    logic [ID_W-1:0]        winner;
    logic                   fin_sel;
    logic signed [OP_W-1:0] op_a;
    logic signed [OP_W-1:0] op_b;

`ifdef MULT_SHARE_RR_EN
    logic [ID_W-1:0] rr_last;
    int              rr_idx;

    // Search begins one past the last winner; the pointer resets to the top client so client 0 wins first.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_idx = 0;
        for (int off = 1; off <= NUM_CLIENTS; off++) begin
            rr_idx = (int'(rr_last) + off) % NUM_CLIENTS;
            if (!found && req[rr_idx]) begin
                found  = 1'b1;
                winner = ID_W'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= ID_W'(NUM_CLIENTS - 1);
        end else if (state == IDLE && found) begin
            rr_last <= winner;
        end
    end
`else
    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        found  = |req;
        winner = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (req[i]) winner = ID_W'(i);
        end
    end
`endif

    // Client 0 feeds the multiplier while idle; the granted client feeds it otherwise.
    always_comb begin
        op_a    = mult_a[0];
        op_b    = mult_b[0];
        fin_sel = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_id == ID_W'(i)) begin
                fin_sel = finish[i];
                if (state != IDLE) begin
                    op_a = mult_a[i];
                    op_b = mult_b[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start       <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            run_cnt     <= '0;
        end else begin
            start       <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        start    <= NUM_CLIENTS'(1) << winner;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    run_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    // A finish arriving in the final allowed cycle beats the timeout.
                    if (fin_sel) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    mult_pipe u_mult_pipe (
        .clk (clk),
        .rst (rst),
        .a   (op_a),
        .b   (op_b),
        .p   (mult_p)
    );

endmodule
